// File: rtl/pc_redirect_unit_pkg.sv
// Shared control encodings for the PC redirect path.
// Holds NPC select, branch condition and jump kind codes.
package pc_redirect_unit_pkg;

   typedef enum logic [1:0] {
      NPC_PLUS4    = 2'd0,
      NPC_BRANCH   = 2'd1,
      NPC_JUMP_IMM = 2'd2,
      NPC_JUMP_REG = 2'd3
   } npc_op_e;

   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LEZ = 3'd2,
      BR_GTZ = 3'd3,
      BR_LTZ = 3'd4,
      BR_GEZ = 3'd5
   } br_cond_e;

   typedef enum logic [1:0] {
      JUMP_NONE = 2'd0,
      JUMP_IMM  = 2'd1,
      JUMP_REG  = 2'd2
   } jump_e;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } pru_state_e;

endpackage

// File: rtl/pc_redirect_unit_br_cond_eval.sv
// Branch condition evaluator from ALU zero/sign flags.
// Codes 6-7 are never taken.
module br_cond_eval
   import pc_redirect_unit_pkg::*;
(
   input  logic [2:0] br_cond_i,
   input  logic       zero_i,
   input  logic       neg_i,
   output logic       cond_o
);

   always_comb begin
      cond_o = 1'b0;
      case (br_cond_i)
         BR_EQ:   cond_o = zero_i;
         BR_NE:   cond_o = !zero_i;
         BR_LEZ:  cond_o = neg_i | zero_i;
         BR_GTZ:  cond_o = !neg_i & !zero_i;
         BR_LTZ:  cond_o = neg_i;
         BR_GEZ:  cond_o = !neg_i;
         default: cond_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_redirect_unit.sv
// PC register and EX redirect resolver with stall-pending hold.
// Optional misaligned-target trap: PC_ALIGN_TRAP_EN.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter int              ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_3000,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              res_valid_i,
   input  logic [1:0]        jump_i,
   input  logic              branch_i,
   input  logic [2:0]        br_cond_i,
   input  logic              zero_i,
   input  logic              neg_i,
   input  logic [ADDR_W-1:0] ex_pc_i,
   input  logic [25:0]       imm26_i,
   input  logic [15:0]       br_off_i,
   input  logic [ADDR_W-1:0] reg_tgt_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [1:0]        npc_op_o,
   output logic              flush_o,
   output logic              pending_o,
   output logic              addr_err_o
);

   pru_state_e        state_q, state_n;
   logic [ADDR_W-1:0] pc_q, pc_n, tgt_q, tgt_n;
   logic [ADDR_W-1:0] pc4, imm_tgt, br_tgt, off_x;
   logic [ADDR_W-1:0] raw_tgt, tgt;
   logic              cond, jmp_imm, jmp_reg, taken;
   npc_op_e           kind;
   logic              err;

   br_cond_eval u_cond (
      .br_cond_i (br_cond_i),
      .zero_i    (zero_i),
      .neg_i     (neg_i),
      .cond_o    (cond)
   );

   assign jmp_imm = (jump_i == JUMP_IMM);
   assign jmp_reg = (jump_i == JUMP_REG);
   assign taken   = res_valid_i & (jmp_imm | jmp_reg | (branch_i & cond));

   always_comb begin
      pc4           = ex_pc_i + ADDR_W'(4);
      imm_tgt       = pc4;
      imm_tgt[27:0] = {imm26_i, 2'b00};
      off_x         = {{(ADDR_W-16){br_off_i[15]}}, br_off_i};
      br_tgt        = pc4 + {off_x[ADDR_W-3:0], 2'b00};
      kind          = NPC_BRANCH;
      raw_tgt       = br_tgt;
      // Jump outranks a simultaneously flagged branch
      if (jmp_imm) begin
         kind    = NPC_JUMP_IMM;
         raw_tgt = imm_tgt;
      end else if (jmp_reg) begin
         kind    = NPC_JUMP_REG;
         raw_tgt = reg_tgt_i;
      end
   end

`ifdef PC_ALIGN_TRAP_EN
   logic misal;
   assign misal = |raw_tgt[1:0];
   assign tgt   = misal ? EXC_VECTOR : raw_tgt;
`else
   logic unused_exc;
   assign unused_exc = ^EXC_VECTOR;
   assign tgt        = {raw_tgt[ADDR_W-1:2], 2'b00};
`endif

   always_comb begin
      state_n  = state_q;
      pc_n     = pc_q;
      tgt_n    = tgt_q;
      flush_o  = 1'b0;
      npc_op_o = NPC_PLUS4;
      err      = 1'b0;
      unique case (state_q)
         RUN: begin
            if (taken) begin
               flush_o  = 1'b1;
               npc_op_o = kind;
`ifdef PC_ALIGN_TRAP_EN
               err      = misal;
`endif
               if (stall_i) begin
                  tgt_n   = tgt;
                  state_n = PEND;
               end else begin
                  pc_n = tgt;
               end
            end else if (!stall_i) begin
               pc_n = pc_q + ADDR_W'(4);
            end
         end
         PEND: begin
            // Younger resolutions were flushed with the original redirect
            if (!stall_i) begin
               pc_n    = tgt_q;
               state_n = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
      end else begin
         state_q <= state_n;
         pc_q    <= pc_n;
         tgt_q   <= tgt_n;
      end
   end

   assign pc_o       = pc_q;
   assign pending_o  = (state_q == PEND);
   assign addr_err_o = err;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with a cycle model.
// Literal checks pin the model to hand-computed PCs.
module tb_pc_redirect_unit;
   import pc_redirect_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall_i, res_valid_i, branch_i, zero_i, neg_i;
   logic [1:0]  jump_i;
   logic [2:0]  br_cond_i;
   logic [31:0] ex_pc_i, reg_tgt_i;
   logic [25:0] imm26_i;
   logic [15:0] br_off_i;
   logic [31:0] pc_o;
   logic [1:0]  npc_op_o;
   logic        flush_o, pending_o, addr_err_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_pc, m_tgt;
   logic        m_pend;
   logic        chk_en = 1'b0;

   always #5 clk = ~clk;

   pc_redirect_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .res_valid_i (res_valid_i),
      .jump_i      (jump_i),
      .branch_i    (branch_i),
      .br_cond_i   (br_cond_i),
      .zero_i      (zero_i),
      .neg_i       (neg_i),
      .ex_pc_i     (ex_pc_i),
      .imm26_i     (imm26_i),
      .br_off_i    (br_off_i),
      .reg_tgt_i   (reg_tgt_i),
      .pc_o        (pc_o),
      .npc_op_o    (npc_op_o),
      .flush_o     (flush_o),
      .pending_o   (pending_o),
      .addr_err_o  (addr_err_o)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Condition judged on a representative ALU value implied by the flags
   function automatic bit m_cond();
      int v;
      v = neg_i ? -1 : (zero_i ? 0 : 1);
      case (br_cond_i)
         3'd0: return v == 0;
         3'd1: return v != 0;
         3'd2: return v <= 0;
         3'd3: return v > 0;
         3'd4: return v < 0;
         3'd5: return v >= 0;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_taken();
      if (!res_valid_i) return 0;
      if (jump_i == 2'd1 || jump_i == 2'd2) return 1;
      return branch_i && m_cond();
   endfunction

   function automatic logic [1:0] m_kind();
      if (jump_i == 2'd1) return NPC_JUMP_IMM;
      if (jump_i == 2'd2) return NPC_JUMP_REG;
      return NPC_BRANCH;
   endfunction

   function automatic logic [31:0] m_raw();
      logic [31:0] nxt;
      int          off;
      nxt = ex_pc_i + 32'd4;
      off = int'($signed(br_off_i)) * 4;
      if (jump_i == 2'd1)
         return (nxt & 32'hF000_0000) | ({6'd0, imm26_i} * 32'd4);
      if (jump_i == 2'd2) return reg_tgt_i;
      return nxt + 32'(off);
   endfunction

   function automatic bit m_misal();
      return (m_raw() % 4) != 0;
   endfunction

   function automatic logic [31:0] m_target();
`ifdef PC_ALIGN_TRAP_EN
      if (m_misal()) return 32'h0000_4180;
      return m_raw();
`else
      return m_raw() - (m_raw() % 4);
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pc   <= 32'h0000_3000;
         m_pend <= 1'b0;
         m_tgt  <= 32'd0;
         chk_en <= 1'b1;
      end else if (m_pend) begin
         if (!stall_i) begin
            m_pc   <= m_tgt;
            m_pend <= 1'b0;
         end
      end else if (m_taken()) begin
         if (stall_i) begin
            m_tgt  <= m_target();
            m_pend <= 1'b1;
         end else begin
            m_pc <= m_target();
         end
      end else if (!stall_i) begin
         m_pc <= m_pc + 32'd4;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic       e_fl, e_err;
         logic [1:0] e_op;
         e_fl  = !m_pend && m_taken();
         e_op  = e_fl ? m_kind() : NPC_PLUS4;
`ifdef PC_ALIGN_TRAP_EN
         e_err = e_fl && m_misal();
`else
         e_err = 1'b0;
`endif
         chk("m_pc", pc_o, m_pc);
         chk("m_flush", 32'(flush_o), 32'(e_fl));
         chk("m_op", 32'(npc_op_o), 32'(e_op));
         chk("m_pend", 32'(pending_o), 32'(m_pend));
         chk("m_err", 32'(addr_err_o), 32'(e_err));
      end
   end

   task automatic idle();
      res_valid_i = 0; jump_i = 0; branch_i = 0; br_cond_i = 0;
      zero_i = 0; neg_i = 0; ex_pc_i = 0; imm26_i = 0;
      br_off_i = 0; reg_tgt_i = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      stall_i = 0;
      rst = 1;
      cyc(); cyc();
      rst = 0;
      chk("rst_pc", pc_o, 32'h3000);
      chk("rst_flush", 32'(flush_o), 0);
      chk("rst_pend", 32'(pending_o), 0);
      chk("rst_err", 32'(addr_err_o), 0);
      cyc(); chk("run1", pc_o, 32'h3004);
      cyc(); chk("run2", pc_o, 32'h3008);

      res_valid_i = 1; branch_i = 1; br_cond_i = 3'd1;
      ex_pc_i = 32'h3010; br_off_i = 16'hFFFC;
      #1;
      chk("ne_flush", 32'(flush_o), 1);
      chk("ne_op", 32'(npc_op_o), 32'(NPC_BRANCH));
      cyc(); idle();
      chk("ne_pc", pc_o, 32'h3004);

      res_valid_i = 1; branch_i = 1; br_cond_i = 3'd5; neg_i = 1;
      ex_pc_i = 32'h3000; br_off_i = 16'h0040;
      #1; chk("gez_flush", 32'(flush_o), 0);
      cyc(); idle();
      chk("gez_pc", pc_o, 32'h3008);

      res_valid_i = 1; branch_i = 1; br_cond_i = 3'd2; zero_i = 1;
      ex_pc_i = 32'h3008; br_off_i = 16'h0010;
      #1; chk("lez_flush", 32'(flush_o), 1);
      cyc(); idle();
      chk("lez_pc", pc_o, 32'h304C);

      res_valid_i = 1; jump_i = 2; reg_tgt_i = 32'h0040_0020;
      stall_i = 1;
      #1;
      chk("jr_flush", 32'(flush_o), 1);
      chk("jr_pend0", 32'(pending_o), 0);
      cyc(); idle();
      chk("jr_pend1", 32'(pending_o), 1);
      chk("jr_hold", pc_o, 32'h304C);
      res_valid_i = 1; jump_i = 1; imm26_i = 26'h3FF_FFFF;
      #1; chk("pend_ign", 32'(flush_o), 0);
      cyc(); idle();
      chk("jr_pend2", 32'(pending_o), 1);
      cyc();
      chk("jr_pend3", 32'(pending_o), 1);
      chk("jr_hold3", pc_o, 32'h304C);
      stall_i = 0;
      cyc();
      chk("jr_pc", pc_o, 32'h0040_0020);
      chk("jr_pend4", 32'(pending_o), 0);

      res_valid_i = 1; jump_i = 1; branch_i = 1; br_cond_i = 3'd0;
      zero_i = 1; ex_pc_i = 32'h3000; imm26_i = 26'h0000100;
      #1; chk("jb_op", 32'(npc_op_o), 32'(NPC_JUMP_IMM));
      cyc(); idle();
      chk("jb_pc", pc_o, 32'h0000_0400);

      res_valid_i = 1; jump_i = 3;
      #1; chk("j3_flush", 32'(flush_o), 0);
      cyc(); idle();
      chk("j3_pc", pc_o, 32'h0000_0404);

      res_valid_i = 1; branch_i = 1; br_cond_i = 3'd6; zero_i = 1;
      #1; chk("c6_flush", 32'(flush_o), 0);
      cyc(); idle();
      chk("c6_pc", pc_o, 32'h0000_0408);

      res_valid_i = 1; jump_i = 2; reg_tgt_i = 32'h5000; stall_i = 1;
      cyc(); idle();
      chk("rp_pend", 32'(pending_o), 1);
      rst = 1;
      cyc();
      rst = 0; stall_i = 0;
      chk("rp_pc", pc_o, 32'h3000);
      chk("rp_pend0", 32'(pending_o), 0);

      res_valid_i = 1; jump_i = 2; reg_tgt_i = 32'hFFFF_FFFC;
      cyc(); idle();
      chk("wr_pc", pc_o, 32'hFFFF_FFFC);
      cyc();
      chk("wr_wrap", pc_o, 32'h0);

      res_valid_i = 1; branch_i = 1; br_cond_i = 3'd3;
      ex_pc_i = 32'h0002_0000; br_off_i = 16'h8000;
      cyc(); idle();
      chk("boff_pc", pc_o, 32'h4);

      res_valid_i = 1; jump_i = 2; reg_tgt_i = 32'h3002;
      #1;
`ifdef PC_ALIGN_TRAP_EN
      chk("al_err", 32'(addr_err_o), 1);
`else
      chk("al_err", 32'(addr_err_o), 0);
`endif
      cyc(); idle();
`ifdef PC_ALIGN_TRAP_EN
      chk("al_pc", pc_o, 32'h4180);
`else
      chk("al_pc", pc_o, 32'h3000);
`endif
      chk("al_err0", 32'(addr_err_o), 0);
      cyc(); cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Next-generation PC source block for the pipelined MIPS core. Generalises the single-cycle NPC-select logic.
- Owns the PC register and evaluates six branch conditions. Resolves jump/branch redirects from EX.
- Holds a redirect that arrives during a fetch stall and issues a one-cycle flush to IF/ID.
- Sits between the EX-stage branch resolver and the instruction-memory address port.

Parameters:
- ADDR_W, 32, PC and target width (>=28).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, trap target; used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  fetch stall; PC must hold
- res_valid_i  in  1  EX holds a valid control-transfer resolution this cycle
- jump_i  in  2  0 none, 1 imm (J/JAL), 2 reg (JR/JALR), 3 reserved (treated as none)
- branch_i  in  1  EX instruction is a conditional branch
- br_cond_i  in  3  0 EQ, 1 NE, 2 LEZ, 3 GTZ, 4 LTZ, 5 GEZ, 6-7 never taken
- zero_i  in  1  ALU result == 0
- neg_i  in  1  ALU result sign bit
- ex_pc_i  in  ADDR_W  PC of the resolving instruction
- imm26_i  in  26  jump index
- br_off_i  in  16  branch offset (words)
- reg_tgt_i  in  ADDR_W  register target
- pc_o  out  ADDR_W  current fetch PC
- npc_op_o  out  2  NPC_PLUS4 / NPC_BRANCH / NPC_JUMP_IMM / NPC_JUMP_REG for the cycle
- flush_o  out  1  kill IF/ID contents
- pending_o  out  1  a redirect is latched, awaiting stall release
- addr_err_o  out  1  misaligned target trap (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst=1 at a clk edge): pc_o=RESET_PC, state RUN, pending target cleared. flush_o, pending_o and addr_err_o are 0 in the cycle after the reset edge. Reset overrides any pending redirect.
- Condition truth:
  - EQ: zero.
  - NE: !zero.
  - LEZ: neg|zero.
  - GTZ: !neg&!zero.
  - LTZ: neg.
  - GEZ: !neg.
- taken = res_valid_i & (jump_i==1 | jump_i==2 | (branch_i & cond)). Jump has priority over branch.
- Target computation, all modulo 2^ADDR_W:
  - JUMP_IMM: {(ex_pc_i+4)[ADDR_W-1:28], imm26_i, 2'b00}.
  - JUMP_REG: reg_tgt_i.
  - BRANCH: ex_pc_i + 4 + (sext(br_off_i)<<2).
- npc_op_o is combinational. It shows the selected kind when taken, otherwise NPC_PLUS4. It reads NPC_PLUS4 in state PEND.
- State RUN:
  - taken & !stall_i: pc <= target next edge; flush_o=1 this cycle (combinational); stay RUN.
  - taken & stall_i: latch target; flush_o=1 this cycle; go PEND; pc holds.
  - !taken & !stall_i: pc <= pc+4, wrapping at 2^ADDR_W.
  - !taken & stall_i: hold.
- State PEND (pending_o=1):
  - stall_i=1: hold pc and latched target.
  - stall_i=0: pc <= latched target; go RUN.
  - res_valid_i in PEND is ignored (younger, already flushed). flush_o=0.
- flush_o is never asserted for a not-taken branch. Latency from resolution to new fetch PC is 1 cycle when not stalled.

Optional Feature:
- Macro: PC_ALIGN_TRAP_EN.
- Defined: a taken target with [1:0]!=0 is replaced by EXC_VECTOR. addr_err_o pulses 1 in the same cycle as flush_o. The PEND path latches EXC_VECTOR.
- Undefined: target[1:0] forced to 2'b00 and addr_err_o tied 0.

Decomposition:
- Shared constants go in the existing control-encoding include:
  - NPC_PLUS4, NPC_BRANCH, NPC_JUMP_IMM, NPC_JUMP_REG.
  - New BR_EQ..BR_GEZ codes.
  - JUMP_NONE/IMM/REG codes.
- One sub-module, br_cond_eval: combinational (br_cond_i, zero_i, neg_i) -> cond. It is reused by the forwarding-compare logic later.

Test Plan:
- Reset, then 3 free-running cycles -> pc_o 0x3000, 0x3004, 0x3008; flush_o=0.
- ex_pc=0x3010, BR_NE, zero=0, off=0xFFFC, no stall -> flush_o=1 that cycle; next pc_o=0x3004; npc_op_o=NPC_BRANCH.
- BR_GEZ with neg=1 -> not taken, flush_o=0, pc advances +4. Repeat with BR_LEZ, zero=1 -> taken.
- JR reg_tgt=0x0040_0020 while stall_i=1 for 3 cycles -> flush_o=1 for 1 cycle; pending_o=1 for 3 cycles; pc_o held. On release, pc_o=0x0040_0020. A res_valid_i during PEND is ignored.
- jump_i=1 and branch_i=1 together, ex_pc=0x3000, imm26=0x0000100 -> target 0x0000_0400 (jump wins); jump_i=3 with no branch -> +4.
- rst asserted while PEND -> pc_o=RESET_PC, pending_o=0. With PC_ALIGN_TRAP_EN, JR to 0x3002 -> pc_o=0x4180, addr_err_o=1 for one cycle.
